// File: rtl/weight_loader.sv
// weight_loader: streams one neuron's weights into its weight memory.
// A start pulse selects the target neuron; each accepted stream word is
// written one cycle later at the next address. A full set of numWeight
// words ends with a one-cycle done pulse. An out-of-range neuron or an
// early in_last ends with a one-cycle err pulse.
module weight_loader #(
    parameter int numWeight    = 784,
    parameter int numNeurons   = 30,
    parameter int neuronWidth  = 5,
    parameter int dataWidth    = 16,
    parameter int addressWidth = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [neuronWidth-1:0]  neuron_sel,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [addressWidth-1:0] last_addr    = addressWidth'(numWeight - 1);
    localparam logic [31:0]             neuron_count = 32'(numNeurons);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [neuronWidth-1:0]  sel_r;
    logic [addressWidth-1:0] cnt_r;
    logic                    sel_ok_s;
    logic                    hs_s;
    logic                    at_last_s;

    logic [numNeurons-1:0]   wen_s;
    logic [addressWidth-1:0] wadd_s;
    logic [dataWidth-1:0]    win_s;
    logic                    busy_s;
    logic                    done_s;
    logic                    err_s;

    logic [numNeurons-1:0]   wen_r;
    logic [addressWidth-1:0] wadd_r;
    logic [dataWidth-1:0]    win_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    // One-hot decode of a neuron index into the per-memory write enable.
    function automatic logic [numNeurons-1:0] onehot(input logic [neuronWidth-1:0] idx);
        logic [numNeurons-1:0] v;
        for (int i = 0; i < numNeurons; i++) begin
            v[i] = (32'(idx) == 32'(i));
        end
        return v;
    endfunction

    assign sel_ok_s  = (32'(neuron_sel) < neuron_count);
    assign in_ready  = (state_r == LOAD);
    assign hs_s      = in_valid & in_ready;
    assign at_last_s = (cnt_r == last_addr);

    assign wen  = wen_r;
    assign wadd = wadd_r;
    assign win  = win_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: the final word always completes the load, even without in_last.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && sel_ok_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (hs_s && at_last_s) begin
                    next_state_s = DONE;
                end else if (hs_s && in_last) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; address and data hold between writes.
    always_comb begin
        wen_s  = {numNeurons{1'b0}};
        wadd_s = wadd_r;
        win_s  = win_r;
        done_s = 1'b0;
        err_s  = 1'b0;
        busy_s = (next_state_s != IDLE);
        case (state_r)
            IDLE: begin
                if (start && !sel_ok_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            LOAD: begin
                if (hs_s) begin
                    wen_s  = onehot(sel_r);
                    wadd_s = cnt_r;
                    win_s  = in_data;
                    err_s  = in_last & ~at_last_s;
                end else begin
                    err_s  = 1'b0;
                end
            end
            DONE:    done_s = 1'b1;
            default: done_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r  <= {numNeurons{1'b0}};
            wadd_r <= {addressWidth{1'b0}};
            win_r  <= {dataWidth{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wen_r  <= wen_s;
            wadd_r <= wadd_s;
            win_r  <= win_s;
            busy_r <= busy_s;
            done_r <= done_s;
            err_r  <= err_s;
        end
    end

    // Target neuron latch and word counter; the counter saturates at the last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r <= {neuronWidth{1'b0}};
            cnt_r <= {addressWidth{1'b0}};
        end else if ((state_r == IDLE) && start && sel_ok_s) begin
            sel_r <= neuron_sel;
            cnt_r <= {addressWidth{1'b0}};
        end else if (hs_s && !at_last_s) begin
            sel_r <= sel_r;
            cnt_r <= cnt_r + addressWidth'(1);
        end else begin
            sel_r <= sel_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader (numWeight=4, numNeurons=3): directed scenarios
// with hand-computed expectations plus randomized traffic compared every cycle
// against a behavioural model of the loader.
module tb_weight_loader;

    localparam int NW = 4;
    localparam int NN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  neuron_sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [2:0]  wen;
    logic [1:0]  wadd;
    logic [15:0] win;
    logic        busy;
    logic        done;
    logic        err;

    weight_loader #(
        .numWeight(NW), .numNeurons(NN), .neuronWidth(2), .dataWidth(16), .addressWidth(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .neuron_sel(neuron_sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wen(wen), .wadd(wadd), .win(win), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // behavioural model state and expected outputs
    bit          m_load = 1'b0;
    bit          m_fin = 1'b0;
    int          m_cnt = 0;
    int          m_sel = 0;
    logic [2:0]  e_wen = 3'b000;
    logic [1:0]  e_wadd = 2'd0;
    logic [15:0] e_win = 16'd0;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;

    typedef struct {
        int          c;
        logic [2:0]  wen;
        logic [1:0]  wadd;
        logic [15:0] win;
    } wr_t;
    wr_t wlog[$];
    int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One model step per rising edge (or reset assertion).
    task automatic model_step();
        if (rst) begin
            m_load = 1'b0; m_fin = 1'b0; m_cnt = 0; m_sel = 0;
            e_wen = 3'b000; e_wadd = 2'd0; e_win = 16'd0;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else begin
            e_wen = 3'b000; e_done = 1'b0; e_err = 1'b0;
            if (m_fin) begin
                e_done = 1'b1;
                m_fin = 1'b0;
            end else if (m_load) begin
                if (in_valid) begin
                    e_wen  = 3'b001 << m_sel;
                    e_wadd = m_cnt[1:0];
                    e_win  = in_data;
                    if (m_cnt == NW - 1) begin
                        m_load = 1'b0; m_fin = 1'b1;
                    end else if (in_last) begin
                        m_load = 1'b0; e_err = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (start) begin
                if (int'(neuron_sel) < NN) begin
                    m_load = 1'b1; m_sel = int'(neuron_sel); m_cnt = 0;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_busy = m_load || m_fin;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison against the model, plus a log of observed events.
    initial forever begin
        @(negedge clk);
        check("wen", 32'(wen), 32'(e_wen));
        check("wadd", 32'(wadd), 32'(e_wadd));
        check("win", 32'(win), 32'(e_win));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        check("in_ready", 32'(in_ready), 32'(m_load));
        if (wen != 3'b000) wlog.push_back('{cyc, wen, wadd, win});
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (busy) busy_cnt++;
    end

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    endtask

    task automatic drive(input logic s, input logic [1:0] sel, input logic v,
                         input logic [15:0] d, input logic l);
        @(negedge clk);
        start = s; neuron_sel = sel; in_valid = v; in_data = d; in_last = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("rst_wen", 32'(wen), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #2 rst = 1'b0;
        idle(2);

        // full load of neuron 2, back-to-back words
        clear_log();
        drive(1'b1, 2'd2, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b1, 16'((i + 1) * 16'h0011), i == 3);
        idle(4);
        check("s1_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < wlog.size(); i++) begin
            check("s1_wen", 32'(wlog[i].wen), 32'h4);
            check("s1_wadd", 32'(wlog[i].wadd), 32'(i));
            check("s1_win", 32'(wlog[i].win), 32'((i + 1) * 16'h0011));
            if (i > 0) check("s1_b2b", 32'(wlog[i].c - wlog[i-1].c), 32'd1);
        end
        check("s1_done_cnt", 32'(done_cnt), 32'd1);
        if (wlog.size() > 0) check("s1_done_lat", 32'(done_cyc - wlog[wlog.size()-1].c), 32'd1);

        // neuron 0 with in_valid toggling
        clear_log();
        drive(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b0, 2'd0, (k % 2) == 0, 16'hA000 + 16'(k), 1'b0);
        idle(3);
        check("s2_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < wlog.size(); i++) begin
            check("s2_wen", 32'(wlog[i].wen), 32'h1);
            check("s2_wadd", 32'(wlog[i].wadd), 32'(i));
            check("s2_win", 32'(wlog[i].win), 32'(16'hA000 + 16'(2 * i)));
            if (i > 0) check("s2_gap", 32'(wlog[i].c - wlog[i-1].c), 32'd2);
        end
        check("s2_done_cnt", 32'(done_cnt), 32'd1);

        // out-of-range neuron
        clear_log();
        drive(1'b1, 2'd3, 1'b0, 16'd0, 1'b0);
        idle(3);
        check("s3_err_cnt", 32'(err_cnt), 32'd1);
        check("s3_nwrites", 32'(wlog.size()), 32'd0);
        check("s3_busy_cnt", 32'(busy_cnt), 32'd0);

        // early in_last on the 2nd word, then a stray word in IDLE
        clear_log();
        drive(1'b1, 2'd1, 1'b0, 16'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0101, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0202, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 16'hDEAD, 1'b0);
        idle(3);
        check("s4_nwrites", 32'(wlog.size()), 32'd2);
        for (int i = 0; i < wlog.size(); i++) begin
            check("s4_wen", 32'(wlog[i].wen), 32'h2);
            check("s4_wadd", 32'(wlog[i].wadd), 32'(i));
        end
        check("s4_err_cnt", 32'(err_cnt), 32'd1);
        if (wlog.size() > 1) check("s4_err_with_write", 32'(err_cyc), 32'(wlog[1].c));
        check("s4_done_cnt", 32'(done_cnt), 32'd0);
        check("s4_idle_busy", 32'(busy), 32'h0);
        check("s4_idle_ready", 32'(in_ready), 32'h0);

        // asynchronous reset after 2 words
        clear_log();
        drive(1'b1, 2'd1, 1'b0, 16'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0AA0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0BB0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0CC0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("s5_wen", 32'(wen), 32'h0);
        check("s5_wadd", 32'(wadd), 32'h0);
        check("s5_win", 32'(win), 32'h0);
        check("s5_busy", 32'(busy), 32'h0);
        check("s5_done", 32'(done), 32'h0);
        check("s5_err", 32'(err), 32'h0);
        check("s5_in_ready", 32'(in_ready), 32'h0);
        drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        #2 rst = 1'b0;
        idle(2);
        check("s5_nwrites", 32'(wlog.size()), 32'd2);
        for (int i = 0; i < wlog.size(); i++) check("s5_no_wadd2", 32'(wlog[i].wadd == 2'd2), 32'h0);

        // start during LOAD is ignored
        clear_log();
        drive(1'b1, 2'd1, 1'b0, 16'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h1111, 1'b0);
        drive(1'b1, 2'd0, 1'b1, 16'h2222, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h3333, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h4444, 1'b0);
        idle(3);
        check("s6_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < wlog.size(); i++) check("s6_wen", 32'(wlog[i].wen), 32'h2);
        check("s6_done_cnt", 32'(done_cnt), 32'd1);

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end else begin
                drive($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 5) == 0);
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
